// File: rtl/asip_ctrl_pkg.sv
// rtl/asip_ctrl_pkg.sv - control word layout, opcode values and NOP word for the vector ASIP decoder
package asip_ctrl_pkg;

  typedef struct packed {
    logic [1:0] alu_control;
    logic       reg_write;
    logic       alu_src;
    logic       pc_src;
    logic       imm_src;
    logic       flag_update;
    logic       mem_to_reg;
    logic       mem_write;
    logic       ra2_src;
    logic       ra1_src;
    logic       alu_src1;
    logic       alu_src2;
    logic       zero_to_alu;
  } ctrl_t;

  localparam logic [3:0] OP_MUL  = 4'h0;
  localparam logic [3:0] OP_DIV  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;

  localparam ctrl_t CTRL_NOP = ctrl_t'(14'b00_0000_0100_0000);

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_B) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// rtl/ctrl_decode_rom.sv - combinational opcode to control word lookup with illegal-opcode flag
module ctrl_decode_rom
  import asip_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  logic [OPCODE_W-1:0] upper;
  assign upper = opcode >> 4;

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (|upper) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_MUL:  ctrl = ctrl_t'(14'b01_1000_1100_0010);
        OP_DIV:  ctrl = ctrl_t'(14'b10_1000_1100_0010);
        OP_LD:   ctrl = ctrl_t'(14'b00_1101_1000_0101);
        OP_ST:   ctrl = ctrl_t'(14'b00_0101_0011_0101);
        OP_ADD:  ctrl = ctrl_t'(14'b00_1000_1100_0000);
        OP_SUB:  ctrl = ctrl_t'(14'b11_1000_1100_0000);
        OP_ADDI: ctrl = ctrl_t'(14'b00_1100_1100_0101);
        OP_SUBI: ctrl = ctrl_t'(14'b11_1100_1100_0101);
        OP_B:    ctrl = ctrl_t'(14'b00_0110_1101_1100);
        OP_BEQ:  ctrl = ctrl_t'(14'b11_0010_1100_0010);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vec_decode_sequencer.sv
// rtl/vec_decode_sequencer.sv - registered decoder that expands vector instructions into lane-masked beats
module vec_decode_sequencer
  import asip_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int LANES    = 4,
  parameter int VLEN_MAX = 16,
  parameter int VL_W     = $clog2(VLEN_MAX + 1),
  parameter int BEAT_W   = ((VLEN_MAX / LANES) > 1) ? $clog2(VLEN_MAX / LANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic                in_is_vec,
  input  logic [VL_W-1:0]     in_vlen,
  output logic                out_valid,
  input  logic                out_ready,
  output ctrl_t               out_ctrl,
  output logic [BEAT_W-1:0]   out_beat,
  output logic                out_last,
  output logic [LANES-1:0]    out_lane_mask,
  output logic                out_illegal
);

  localparam int LANE_SH = $clog2(LANES);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic              fire, accept, advance;
  ctrl_t             rom_ctrl, ctrl_in, ctrl_q;
  logic              rom_illegal, illegal_in;
  logic              vec_zero, single;
  logic [VL_W-1:0]   vl_sat, vl_in, vl_in_m1, vl_q;
  logic [BEAT_W-1:0] bm1_in, bm1_q, beat_nx;

  ctrl_decode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .opcode  (in_opcode),
    .ctrl    (rom_ctrl),
    .illegal (rom_illegal)
  );

  function automatic logic [LANES-1:0] lane_mask(input logic [BEAT_W-1:0] b,
                                                 input logic [VL_W-1:0] vl);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (int'(b) * LANES + i) < int'(vl);
    end
    return m;
  endfunction

  // Only the final beat of an instruction may update flags.
  function automatic ctrl_t gate_flag(input ctrl_t c, input logic last);
    ctrl_t r;
    r             = c;
    r.flag_update = c.flag_update & last;
    return r;
  endfunction

  // Scalar, branch and illegal opcodes act as a single one-element beat;
  // a zero-length vector becomes a single empty-mask NOP.
  always_comb begin
    vl_sat     = (in_vlen > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : in_vlen;
    vec_zero   = in_is_vec && (in_vlen == '0);
    single     = !in_is_vec || rom_illegal || is_branch(in_opcode[3:0]);
    ctrl_in    = rom_ctrl;
    illegal_in = rom_illegal;
    vl_in      = vl_sat;
    if (vec_zero) begin
      vl_in      = '0;
      ctrl_in    = CTRL_NOP;
      illegal_in = 1'b1;
    end else if (single) begin
      vl_in = VL_W'(1);
    end
    vl_in_m1 = (vl_in == '0) ? '0 : vl_in - VL_W'(1);
    bm1_in   = BEAT_W'(vl_in_m1 >> LANE_SH);
  end

  always_comb begin
    state_d  = state_q;
    fire     = (state_q == ISSUE) && out_ready;
    in_ready = !rst && ((state_q == IDLE) || (fire && out_last));
    accept   = in_valid && in_ready;
    advance  = fire && !out_last;
    beat_nx  = out_beat + BEAT_W'(1);
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (fire && out_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      out_ctrl      <= CTRL_NOP;
      out_beat      <= '0;
      out_last      <= 1'b0;
      out_lane_mask <= '0;
      out_illegal   <= 1'b0;
      ctrl_q        <= CTRL_NOP;
      vl_q          <= '0;
      bm1_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q        <= ctrl_in;
        vl_q          <= vl_in;
        bm1_q         <= bm1_in;
        out_beat      <= '0;
        out_last      <= (bm1_in == '0);
        out_lane_mask <= lane_mask('0, vl_in);
        out_illegal   <= illegal_in;
        out_ctrl      <= gate_flag(ctrl_in, bm1_in == '0);
      end else if (advance) begin
        out_beat      <= beat_nx;
        out_last      <= (beat_nx == bm1_q);
        out_lane_mask <= lane_mask(beat_nx, vl_q);
        out_ctrl      <= gate_flag(ctrl_q, beat_nx == bm1_q);
      end
    end
  end

endmodule

// File: tb/tb_vec_decode_sequencer.sv
// tb/tb_vec_decode_sequencer.sv - scoreboard bench for vec_decode_sequencer with directed vectors
module tb_vec_decode_sequencer;
  import asip_ctrl_pkg::*;

  localparam logic [13:0] C_NOP   = 14'b00_0000_0100_0000;
  localparam logic [13:0] C_ADD   = 14'b00_1000_1100_0000;
  localparam logic [13:0] C_ADDNF = 14'b00_1000_0100_0000;
  localparam logic [13:0] C_SUB   = 14'b11_1000_1100_0000;
  localparam logic [13:0] C_SUBNF = 14'b11_1000_0100_0000;
  localparam logic [13:0] C_MUL   = 14'b01_1000_1100_0010;
  localparam logic [13:0] C_MULNF = 14'b01_1000_0100_0010;
  localparam logic [13:0] C_LD    = 14'b00_1101_1000_0101;
  localparam logic [13:0] C_ST    = 14'b00_0101_0011_0101;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_is_vec;
  logic [3:0] in_opcode;
  logic [4:0] in_vlen;
  logic       out_valid, out_ready, out_last, out_illegal;
  ctrl_t      out_ctrl;
  logic [1:0] out_beat;
  logic [3:0] out_lane_mask;

  always #5 clk = ~clk;

  vec_decode_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_is_vec     (in_is_vec),
    .in_vlen       (in_vlen),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_beat      (out_beat),
    .out_last      (out_last),
    .out_lane_mask (out_lane_mask),
    .out_illegal   (out_illegal)
  );

  typedef struct packed {
    logic [13:0] ctrl;
    logic [1:0]  beat;
    logic        last;
    logic [3:0]  mask;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [13:0] c, input logic [1:0] b, input logic l,
                      input logic [3:0] m, input logic i);
    exp_t e;
    e.ctrl = c;
    e.beat = b;
    e.last = l;
    e.mask = m;
    e.ill  = i;
    q.push_back(e);
  endtask

  // Compares every presented beat with the queue head; pops only on fire.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat %0d with nothing expected", out_beat);
      end else begin
        mon_e = q[0];
        check(out_ready ? "fire_ctrl" : "hold_ctrl", 32'(out_ctrl), 32'(mon_e.ctrl));
        check(out_ready ? "fire_beat" : "hold_beat", 32'(out_beat), 32'(mon_e.beat));
        check(out_ready ? "fire_last" : "hold_last", 32'(out_last), 32'(mon_e.last));
        check(out_ready ? "fire_mask" : "hold_mask", 32'(out_lane_mask), 32'(mon_e.mask));
        check(out_ready ? "fire_ill" : "hold_ill", 32'(out_illegal), 32'(mon_e.ill));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic vec, input logic [4:0] vl,
                      output int waited);
    in_opcode = op;
    in_is_vec = vec;
    in_vlen   = vl;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: opcode %0h never accepted", op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ctrl"}, 32'(out_ctrl), 32'(C_NOP));
    check({tag, "_beat"}, 32'(out_beat), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_mask"}, 32'(out_lane_mask), 32'd0);
    check({tag, "_ill"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1, w2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'h0;
    in_is_vec = 1'b0;
    in_vlen   = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_reset_outputs("rst");
    rst = 1'b0;

    // scalar ADD, one-cycle latency
    push(C_ADD, 2'd0, 1'b1, 4'b0001, 1'b0);
    send(4'h4, 1'b0, 5'd0, w1);
    check("add_latency_valid", 32'(out_valid), 32'd1);
    drain("add");

    // vector SUB, vlen 10
    push(C_SUBNF, 2'd0, 1'b0, 4'b1111, 1'b0);
    push(C_SUBNF, 2'd1, 1'b0, 4'b1111, 1'b0);
    push(C_SUB,   2'd2, 1'b1, 4'b0011, 1'b0);
    send(4'h5, 1'b1, 5'd10, w1);
    drain("sub");

    // vector MUL, vlen 16, stall on beat 1
    push(C_MULNF, 2'd0, 1'b0, 4'b1111, 1'b0);
    push(C_MULNF, 2'd1, 1'b0, 4'b1111, 1'b0);
    push(C_MULNF, 2'd2, 1'b0, 4'b1111, 1'b0);
    push(C_MUL,   2'd3, 1'b1, 4'b1111, 1'b0);
    send(4'h0, 1'b1, 5'd16, w1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("mul_stall");

    // back-to-back LD then ST
    push(C_LD, 2'd0, 1'b1, 4'b0001, 1'b0);
    push(C_ST, 2'd0, 1'b1, 4'b0001, 1'b0);
    send(4'h2, 1'b0, 5'd0, w1);
    send(4'h3, 1'b0, 5'd0, w2);
    check("b2b_ld_wait", 32'(w1), 32'd0);
    check("b2b_st_wait", 32'(w2), 32'd0);
    check("b2b_st_valid", 32'(out_valid), 32'd1);
    drain("b2b");

    // illegal opcode, zero-length vector, oversized vlen
    push(C_NOP, 2'd0, 1'b1, 4'b0001, 1'b1);
    send(4'hA, 1'b0, 5'd0, w1);
    drain("illegal_op");
    push(C_NOP, 2'd0, 1'b1, 4'b0000, 1'b1);
    send(4'h4, 1'b1, 5'd0, w1);
    drain("vlen0");
    push(C_ADDNF, 2'd0, 1'b0, 4'b1111, 1'b0);
    push(C_ADDNF, 2'd1, 1'b0, 4'b1111, 1'b0);
    push(C_ADDNF, 2'd2, 1'b0, 4'b1111, 1'b0);
    push(C_ADD,   2'd3, 1'b1, 4'b1111, 1'b0);
    send(4'h4, 1'b1, 5'd31, w1);
    drain("vlen31");

    // reset during beat 1 of a 4-beat op
    push(C_MULNF, 2'd0, 1'b0, 4'b1111, 1'b0);
    push(C_MULNF, 2'd1, 1'b0, 4'b1111, 1'b0);
    send(4'h0, 1'b1, 5'd16, w1);
    @(posedge clk);
    #1;
    check("mid_beat_before_rst", 32'(out_beat), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check_reset_outputs("mid_rst");
    push(C_ADD, 2'd0, 1'b1, 4'b0001, 1'b0);
    send(4'h4, 1'b0, 5'd0, w1);
    check("post_rst_accept_wait", 32'(w1), 32'd0);
    drain("post_rst");
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
